// File: rtl/morph_window_3x3.sv
// morph_window_3x3
// 3x3 greyscale morphology window: erosion (min) or dilation (max) over a
// cross (5-tap) or square (9-tap) structuring element. Consumes one vertically
// aligned pixel triple per accepted cycle and emits one filtered centre pixel
// per fully populated window, three clocks after the pixel that completes it.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   valid_in   input triple accepted this cycle
//   din_top    pixel from row y-1
//   din_mid    pixel from row y
//   din_bot    pixel from row y+1
//   mode       0 = erode (min), 1 = dilate (max); sampled at column 0
//   shape      0 = cross, 1 = square; sampled at column 0
//   dout       filtered centre pixel, held while valid_out is low
//   valid_out  dout is valid this cycle
//   eol_out    marks the last output of a line (only with valid_out)
module morph_window_3x3 #(
   parameter int DATA_W    = 8,
   parameter int PIC_WIDTH = 250
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_in,
   input  logic [DATA_W-1:0] din_top,
   input  logic [DATA_W-1:0] din_mid,
   input  logic [DATA_W-1:0] din_bot,
   input  logic              mode,
   input  logic              shape,
   output logic [DATA_W-1:0] dout,
   output logic              valid_out,
   output logic              eol_out
);

   localparam int              COL_W    = $clog2(PIC_WIDTH);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(PIC_WIDTH - 1);
   localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);

   // Column 0 holds the newest pixel, column 2 the oldest.
   logic [DATA_W-1:0] win_top [3];
   logic [DATA_W-1:0] win_mid [3];
   logic [DATA_W-1:0] win_bot [3];

   logic [COL_W-1:0]  col;
   logic              line_mode;
   logic              line_shape;
   logic              wv;
   logic              wv_eol;

   logic [DATA_W-1:0] r_top;
   logic [DATA_W-1:0] r_mid;
   logic [DATA_W-1:0] r_bot;
   logic [DATA_W-1:0] r_ctr;
   logic              s1_valid;
   logic              s1_eol;
   logic              s1_mode;
   logic              s1_shape;

   // Two-input reduction: max when is_max, otherwise min. Ties are
   // interchangeable, so comparison direction on equality does not matter.
   function automatic logic [DATA_W-1:0] pick(
      input logic [DATA_W-1:0] a,
      input logic [DATA_W-1:0] b,
      input logic              is_max
   );
      if (is_max) return (a > b) ? a : b;
      else        return (a < b) ? a : b;
   endfunction

   function automatic logic [DATA_W-1:0] pick3(
      input logic [DATA_W-1:0] a,
      input logic [DATA_W-1:0] b,
      input logic [DATA_W-1:0] c,
      input logic              is_max
   );
      return pick(pick(a, b, is_max), c, is_max);
   endfunction

   // Window shift, column counter and per-line settings latch.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values; the shift chain below depends on that ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         col        <= '0;
         line_mode  <= 1'b0;
         line_shape <= 1'b0;
         wv         <= 1'b0;
         wv_eol     <= 1'b0;
         // NOTE: the window is a handful of flops, not a RAM, so it is cleared
         // explicitly; a partial line must never leak into the next one.
         for (int i = 0; i < 3; i++) begin
            win_top[i] <= '0;
            win_mid[i] <= '0;
            win_bot[i] <= '0;
         end
      end else begin
         wv     <= 1'b0;
         wv_eol <= 1'b0;
         if (valid_in) begin
            col <= (col == COL_LAST) ? '0 : col + COL_W'(1);
            win_top[0] <= din_top;
            win_mid[0] <= din_mid;
            win_bot[0] <= din_bot;
            for (int i = 1; i < 3; i++) begin
               win_top[i] <= win_top[i-1];
               win_mid[i] <= win_mid[i-1];
               win_bot[i] <= win_bot[i-1];
            end
            // Settings change only when a new line starts. Any window still
            // flagged by wv belongs to the old line and is reduced with the old
            // settings on this same edge, before the new ones are visible.
            if (col == '0) begin
               line_mode  <= mode;
               line_shape <= shape;
            end
            if (col >= COL_TWO) wv <= 1'b1;
            if (col == COL_LAST) wv_eol <= 1'b1;
         end
      end
   end

   // Stage 1: per-row reductions plus the vertical centre pair for the cross.
   // Settings are captured with the window so stage 2 never sees a newer line's.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_top    <= '0;
         r_mid    <= '0;
         r_bot    <= '0;
         r_ctr    <= '0;
         s1_valid <= 1'b0;
         s1_eol   <= 1'b0;
         s1_mode  <= 1'b0;
         s1_shape <= 1'b0;
      end else begin
         s1_valid <= wv;
         s1_eol   <= wv_eol;
         if (wv) begin
            r_top    <= pick3(win_top[0], win_top[1], win_top[2], line_mode);
            r_mid    <= pick3(win_mid[0], win_mid[1], win_mid[2], line_mode);
            r_bot    <= pick3(win_bot[0], win_bot[1], win_bot[2], line_mode);
            r_ctr    <= pick(win_top[1], win_bot[1], line_mode);
            s1_mode  <= line_mode;
            s1_shape <= line_shape;
         end
      end
   end

   // Stage 2: combine the partial results according to the kernel shape.
   always_ff @(posedge clk) begin
      if (rst) begin
         dout      <= '0;
         valid_out <= 1'b0;
         eol_out   <= 1'b0;
      end else begin
         valid_out <= s1_valid;
         eol_out   <= s1_eol;
         if (s1_valid) begin
            dout <= s1_shape ? pick3(r_top, r_mid, r_bot, s1_mode)
                             : pick(r_mid, r_ctr, s1_mode);
         end
      end
   end

endmodule

// File: tb/tb_morph_window_3x3.sv
// tb_morph_window_3x3
// Scoreboard bench for morph_window_3x3 with DATA_W=8, PIC_WIDTH=5.
// Stimulus pushes hand-computed expected outputs (value, line-end flag and
// arrival cycle) into a queue; an independent monitor pops and compares on
// every cycle the DUT presents valid_out.
module tb_morph_window_3x3;

   localparam int DATA_W    = 8;
   localparam int PIC_WIDTH = 5;

   typedef logic [7:0] row_t [5];
   typedef logic [7:0] res_t [3];

   typedef struct packed {
      logic [7:0]  data;
      logic        eol;
      logic [31:0] cyc;
   } exp_t;

   logic              clk;
   logic              rst;
   logic              valid_in;
   logic [DATA_W-1:0] din_top;
   logic [DATA_W-1:0] din_mid;
   logic [DATA_W-1:0] din_bot;
   logic              mode;
   logic              shape;
   logic [DATA_W-1:0] dout;
   logic              valid_out;
   logic              eol_out;

   exp_t        exp_q [$];
   exp_t        mon_e;
   int unsigned cyc;
   int          checks;
   int          errors;
   bit          mon_en;
   logic [7:0]  last_dout;

   morph_window_3x3 #(
      .DATA_W    (DATA_W),
      .PIC_WIDTH (PIC_WIDTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .valid_in  (valid_in),
      .din_top   (din_top),
      .din_mid   (din_mid),
      .din_bot   (din_bot),
      .mode      (mode),
      .shape     (shape),
      .dout      (dout),
      .valid_out (valid_out),
      .eol_out   (eol_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0d expected %0d (time %0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: samples on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (mon_en) begin
         if (valid_out) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output actual dout=%0d expected no output (time %0t)",
                        dout, $time);
            end else begin
               mon_e = exp_q.pop_front();
               check("dout", dout, mon_e.data);
               check("eol", eol_out, mon_e.eol);
               check("latency_cycle", cyc, mon_e.cyc);
            end
            last_dout = dout;
         end else begin
            check("eol_idle", eol_out, 0);
            check("dout_hold", dout, last_dout);
         end
      end
   end

   // One line of PIC_WIDTH pixels. md/sh give per-pixel mode/shape (bit i is
   // pixel i); ex holds the three expected outputs; gap idles after each pixel.
   task automatic send_line(input row_t t, input row_t m, input row_t b,
                            input logic [4:0] md, input logic [4:0] sh,
                            input res_t ex, input int gap);
      for (int i = 0; i < 5; i++) begin
         din_top  = t[i];
         din_mid  = m[i];
         din_bot  = b[i];
         mode     = md[i];
         shape    = sh[i];
         valid_in = 1'b1;
         @(posedge clk);
         #1;
         if (i >= 2) exp_q.push_back('{data: ex[i-2], eol: (i == 4), cyc: cyc + 2});
         valid_in = 1'b0;
         repeat (gap) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      checks    = 0;
      errors    = 0;
      mon_en    = 1'b0;
      last_dout = '0;
      cyc       = 0;
      rst       = 1'b1;
      valid_in  = 1'b0;
      din_top   = '0;
      din_mid   = '0;
      din_bot   = '0;
      mode      = 1'b0;
      shape     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("reset_dout", dout, 0);
      check("reset_valid", valid_out, 0);
      check("reset_eol", eol_out, 0);
      mon_en = 1'b1;
      idle(1);

      // Erode square on identical rows: min of each 3-column window.
      send_line('{10, 20, 30, 40, 50}, '{10, 20, 30, 40, 50}, '{10, 20, 30, 40, 50},
                5'b00000, 5'b11111, '{10, 20, 30}, 0);
      idle(4);

      // Dilate cross: vertical centre pair pulls in the 99 from the top row.
      send_line('{99, 99, 99, 99, 99}, '{5, 6, 7, 8, 9}, '{1, 1, 1, 1, 1},
                5'b11111, 5'b00000, '{99, 99, 99}, 0);
      // Erode cross on the same data: the bottom row's 1 wins.
      send_line('{99, 99, 99, 99, 99}, '{5, 6, 7, 8, 9}, '{1, 1, 1, 1, 1},
                5'b00000, 5'b00000, '{1, 1, 1}, 0);
      // Dilate square.
      send_line('{99, 99, 99, 99, 99}, '{5, 6, 7, 8, 9}, '{1, 1, 1, 1, 1},
                5'b11111, 5'b11111, '{99, 99, 99}, 0);
      idle(4);

      // Corner tap: top of pixel 2 is 0. Square sees it in all three windows;
      // cross sees it only when pixel 2 is the centre column.
      send_line('{200, 200, 0, 200, 200}, '{200, 200, 200, 200, 200}, '{200, 200, 200, 200, 200},
                5'b00000, 5'b11111, '{0, 0, 0}, 0);
      send_line('{200, 200, 0, 200, 200}, '{200, 200, 200, 200, 200}, '{200, 200, 200, 200, 200},
                5'b00000, 5'b00000, '{200, 0, 200}, 0);
      idle(4);

      // valid_in every other cycle: same results, latency still 3 clocks.
      send_line('{10, 20, 30, 40, 50}, '{10, 20, 30, 40, 50}, '{10, 20, 30, 40, 50},
                5'b00000, 5'b11111, '{10, 20, 30}, 1);
      idle(4);

      // Mode raised at the 3rd pixel of line 1 (ignored), line 2 dilates.
      // Lines run back-to-back so the boundary window keeps erode.
      send_line('{10, 20, 30, 40, 50}, '{10, 20, 30, 40, 50}, '{10, 20, 30, 40, 50},
                5'b11100, 5'b11111, '{10, 20, 30}, 0);
      send_line('{10, 20, 30, 40, 50}, '{10, 20, 30, 40, 50}, '{10, 20, 30, 40, 50},
                5'b11111, 5'b11111, '{30, 40, 50}, 0);
      idle(4);

      // Partial dilate/square line, reset on its 4th pixel: nothing may emerge.
      for (int i = 0; i < 3; i++) begin
         din_top  = 8'd200;
         din_mid  = 8'd200;
         din_bot  = 8'd200;
         mode     = 1'b1;
         shape    = 1'b1;
         valid_in = 1'b1;
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst       = 1'b0;
      valid_in  = 1'b0;
      last_dout = '0;
      @(negedge clk);
      check("midreset_dout", dout, 0);
      check("midreset_valid", valid_out, 0);
      check("midreset_eol", eol_out, 0);
      idle(4);

      // Fresh line: erode/cross at column 0, later mode/shape changes ignored.
      send_line('{99, 99, 99, 99, 99}, '{5, 6, 7, 8, 9}, '{1, 1, 1, 1, 1},
                5'b11110, 5'b11110, '{1, 1, 1}, 0);

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
      idle(2);
      check("drain_pending", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
